// File: rtl/if_id_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// The fetch stage uses the master side; the memory model or arbiter uses the slave side.
interface if_id_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/if_id_stage.sv
// Fetch stage with IF/ID pipeline register, a one-entry skid buffer for stalls and
// redirect draining. Optional performance counters are enabled by IF_ID_PERF_CNT_EN.
//
// state | meaning
// IDLE  | first cycle after reset, no request
// FETCH | request outstanding at pc_q
// HOLD  | stalled with a fetched word parked in the skid buffer, no request
// DRAIN | redirect arrived mid-request; wait for the stale response, then jump
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          stall_i,
  input  logic          redirect_i,
  input  logic [31:0]   redirect_pc_i,
  if_id_stage_if.master imem,
  output logic [31:0]   inst_o,
  output logic [31:0]   pc_o,
  output logic [31:0]   pcNext_o,
  output logic [4:0]    rs1_o,
  output logic [4:0]    rs2_o,
  output logic [4:0]    rd_o,
  output logic          valid_o,
  output logic [31:0]   fetch_cnt_o,
  output logic [31:0]   bubble_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] skid_inst_q, skid_pc_q;
  logic        skid_ld;
  logic        ld_valid, ld_bubble;
  logic [31:0] ld_inst, ld_pc;
  logic        req;
  logic [31:0] pc_inc;
  logic [31:0] redir_tgt;

  assign pc_inc    = pc_q + 32'd4;
  assign redir_tgt = {redirect_pc_i[31:2], 2'b00};

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    skid_ld   = 1'b0;
    ld_valid  = 1'b0;
    ld_bubble = 1'b0;
    ld_inst   = imem.imem_rdata_i;
    ld_pc     = pc_q;
    req       = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        req = 1'b1;
        if (imem.imem_ready_i) begin
          if (redirect_i) begin
            pc_d      = redir_tgt;
            ld_bubble = 1'b1;
          end else if (stall_i) begin
            skid_ld = 1'b1;
            pc_d    = pc_inc;
            state_d = S_HOLD;
          end else begin
            ld_valid = 1'b1;
            pc_d     = pc_inc;
          end
        end else begin
          // address must stay put while the request is open, so park the target
          if (redirect_i) begin
            tgt_d     = redir_tgt;
            ld_bubble = 1'b1;
            state_d   = S_DRAIN;
          end else if (!stall_i) begin
            ld_bubble = 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (redirect_i) begin
          pc_d      = redir_tgt;
          ld_bubble = 1'b1;
          state_d   = S_FETCH;
        end else if (!stall_i) begin
          ld_valid = 1'b1;
          ld_inst  = skid_inst_q;
          ld_pc    = skid_pc_q;
          state_d  = S_FETCH;
        end
      end

      S_DRAIN: begin
        req = 1'b1;
        if (redirect_i) begin
          tgt_d = redir_tgt;
        end
        if (imem.imem_ready_i) begin
          pc_d    = tgt_d;
          state_d = S_FETCH;
        end
        if (redirect_i || !stall_i) begin
          ld_bubble = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      tgt_q       <= '0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      if (skid_ld) begin
        skid_inst_q <= imem.imem_rdata_i;
        skid_pc_q   <= pc_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      inst_o   <= NOP_INST;
      pc_o     <= '0;
      pcNext_o <= '0;
      rs1_o    <= '0;
      rs2_o    <= '0;
      rd_o     <= '0;
      valid_o  <= 1'b0;
    end else if (ld_valid) begin
      inst_o   <= ld_inst;
      pc_o     <= ld_pc;
      pcNext_o <= ld_pc + 32'd4;
      rs1_o    <= ld_inst[19:15];
      rs2_o    <= ld_inst[24:20];
      rd_o     <= ld_inst[11:7];
      valid_o  <= 1'b1;
    end else if (ld_bubble) begin
      inst_o   <= NOP_INST;
      pc_o     <= '0;
      pcNext_o <= '0;
      rs1_o    <= '0;
      rs2_o    <= '0;
      rd_o     <= '0;
      valid_o  <= 1'b0;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (ld_valid)  fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (ld_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign fetch_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a per-cycle vector table plus hand sequences for
// reset during HOLD/DRAIN and the performance counters.
module tb_if_id_stage;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] inst_o, pc_o, pcNext_o, fetch_cnt_o, bubble_cnt_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic        valid_o;

  int tests  = 0;
  int errors = 0;

  if_id_stage_if imem ();

  if_id_stage #(.RESET_PC(32'h0000_0100), .NOP_INST(32'h0000_0013)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (imem.master),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .pcNext_o      (pcNext_o),
    .rs1_o         (rs1_o),
    .rs2_o         (rs2_o),
    .rd_o          (rd_o),
    .valid_o       (valid_o),
    .fetch_cnt_o   (fetch_cnt_o),
    .bubble_cnt_o  (bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          stall;
    bit          redir;
    logic [31:0] rpc;
    bit          ready;
    bit          ereq;
    logic [31:0] eaddr;
    bit          evalid;
    logic [31:0] einst;
    logic [31:0] epc;
    logic [31:0] epn;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(bit s, bit r, logic [31:0] rpc, bit rdy, bit ereq,
                              logic [31:0] eaddr, bit ev, logic [31:0] ei,
                              logic [31:0] ep, logic [31:0] epn);
    vec_t v;
    v.stall = s;  v.redir = r;  v.rpc = rpc;  v.ready = rdy;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = ev;
    v.einst = ei; v.epc = ep; v.epn = epn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory returns a word derived from the address so captured data is traceable
  task automatic drive(input bit s, input bit r, input logic [31:0] rpc, input bit rdy);
    @(negedge clk_i);
    stall_i           = s;
    redirect_i        = r;
    redirect_pc_i     = rpc;
    imem.imem_ready_i = rdy;
    imem.imem_rdata_i = 32'h1000_0000 | imem.imem_addr_o;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input bit ev, input logic [31:0] ei,
                          input logic [31:0] ep, input logic [31:0] epn);
    logic [31:0] w;
    w = ei;
    chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, ev});
    chk({tag, ".inst"},  inst_o,   ei);
    chk({tag, ".pc"},    pc_o,     ep);
    chk({tag, ".pcnext"}, pcNext_o, epn);
    chk({tag, ".rs1"}, {27'd0, rs1_o}, {27'd0, w[19:15]});
    chk({tag, ".rs2"}, {27'd0, rs2_o}, {27'd0, w[24:20]});
    chk({tag, ".rd"},  {27'd0, rd_o},  {27'd0, w[11:7]});
  endtask

  task automatic chk_req(input string tag, input bit ereq, input logic [31:0] eaddr);
    chk({tag, ".req"},  {31'd0, imem.imem_req_o}, {31'd0, ereq});
    chk({tag, ".addr"}, imem.imem_addr_o, eaddr);
  endtask

  task automatic release_reset();
    @(posedge clk_i);
    #2 reset_i = 1'b1;
  endtask

  task automatic assert_reset_midcycle(input string tag);
    #2 reset_i = 1'b0;
    #1;
    chk_req(tag, 1'b0, 32'h100);
    chk_ifid(tag, 1'b0, 32'h13, 32'h0, 32'h0);
  endtask

  initial begin
    reset_i           = 1'b0;
    stall_i           = 1'b0;
    redirect_i        = 1'b0;
    redirect_pc_i     = '0;
    imem.imem_ready_i = 1'b0;
    imem.imem_rdata_i = '0;

    //            stall redir rpc           rdy  req addr           valid inst           pc             pcnext
    vecs[0]  = mk(0, 0, 32'h0,          1, 0, 32'h100,       0, 32'h13,         32'h0,         32'h0);
    vecs[1]  = mk(0, 0, 32'h0,          1, 1, 32'h100,       1, 32'h1000_0100,  32'h100,       32'h104);
    vecs[2]  = mk(0, 0, 32'h0,          1, 1, 32'h104,       1, 32'h1000_0104,  32'h104,       32'h108);
    vecs[3]  = mk(1, 0, 32'h0,          1, 1, 32'h108,       1, 32'h1000_0104,  32'h104,       32'h108);
    vecs[4]  = mk(1, 0, 32'h0,          1, 0, 32'h10C,       1, 32'h1000_0104,  32'h104,       32'h108);
    vecs[5]  = mk(1, 0, 32'h0,          1, 0, 32'h10C,       1, 32'h1000_0104,  32'h104,       32'h108);
    vecs[6]  = mk(0, 0, 32'h0,          1, 0, 32'h10C,       1, 32'h1000_0108,  32'h108,       32'h10C);
    vecs[7]  = mk(0, 0, 32'h0,          1, 1, 32'h10C,       1, 32'h1000_010C,  32'h10C,       32'h110);
    vecs[8]  = mk(0, 0, 32'h0,          0, 1, 32'h110,       0, 32'h13,         32'h0,         32'h0);
    vecs[9]  = mk(0, 1, 32'h200,        0, 1, 32'h110,       0, 32'h13,         32'h0,         32'h0);
    vecs[10] = mk(0, 0, 32'h0,          0, 1, 32'h110,       0, 32'h13,         32'h0,         32'h0);
    vecs[11] = mk(0, 0, 32'h0,          1, 1, 32'h110,       0, 32'h13,         32'h0,         32'h0);
    vecs[12] = mk(0, 0, 32'h0,          1, 1, 32'h200,       1, 32'h1000_0200,  32'h200,       32'h204);
    vecs[13] = mk(1, 1, 32'hFFFF_FFFF,  1, 1, 32'h204,       0, 32'h13,         32'h0,         32'h0);
    vecs[14] = mk(0, 0, 32'h0,          1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h0);
    vecs[15] = mk(0, 0, 32'h0,          1, 1, 32'h0,         1, 32'h1000_0000,  32'h0,         32'h4);
    vecs[16] = mk(1, 0, 32'h0,          0, 1, 32'h4,         1, 32'h1000_0000,  32'h0,         32'h4);
    vecs[17] = mk(0, 0, 32'h0,          1, 1, 32'h4,         1, 32'h1000_0004,  32'h4,         32'h8);
    vecs[18] = mk(1, 0, 32'h0,          1, 1, 32'h8,         1, 32'h1000_0004,  32'h4,         32'h8);
    vecs[19] = mk(0, 1, 32'h300,        1, 0, 32'hC,         0, 32'h13,         32'h0,         32'h0);
    vecs[20] = mk(0, 0, 32'h0,          1, 1, 32'h300,       1, 32'h1000_0300,  32'h300,       32'h304);
    vecs[21] = mk(0, 1, 32'h400,        0, 1, 32'h304,       0, 32'h13,         32'h0,         32'h0);
    vecs[22] = mk(0, 1, 32'h500,        0, 1, 32'h304,       0, 32'h13,         32'h0,         32'h0);
    vecs[23] = mk(1, 0, 32'h0,          1, 1, 32'h304,       0, 32'h13,         32'h0,         32'h0);
    vecs[24] = mk(0, 0, 32'h0,          1, 1, 32'h500,       1, 32'h1000_0500,  32'h500,       32'h504);

    repeat (2) tick();
    chk_req("reset", 1'b0, 32'h100);
    chk_ifid("reset", 1'b0, 32'h13, 32'h0, 32'h0);
    chk("reset.fetch_cnt",  fetch_cnt_o,  32'h0);
    chk("reset.bubble_cnt", bubble_cnt_o, 32'h0);
    release_reset();

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
      #1;
      chk_req($sformatf("vec%0d", i), vecs[i].ereq, vecs[i].eaddr);
      tick();
      chk_ifid($sformatf("vec%0d", i), vecs[i].evalid, vecs[i].einst, vecs[i].epc, vecs[i].epn);
    end

    // reset while parked in HOLD drops the skid word
    drive(1, 0, 32'h0, 1);
    tick();
    drive(1, 0, 32'h0, 1);
    #1;
    chk_req("hold_entry", 1'b0, 32'h508);
    assert_reset_midcycle("rst_hold");
    release_reset();
    drive(0, 0, 32'h0, 1);
    #1;
    chk_req("rst_hold.idle", 1'b0, 32'h100);
    tick();
    chk_ifid("rst_hold.idle", 1'b0, 32'h13, 32'h0, 32'h0);
    drive(0, 0, 32'h0, 1);
    #1;
    chk_req("rst_hold.fetch", 1'b1, 32'h100);
    tick();
    chk_ifid("rst_hold.fetch", 1'b1, 32'h1000_0100, 32'h100, 32'h104);

    // reset while draining forgets the buffered target
    drive(0, 1, 32'h700, 0);
    tick();
    drive(0, 0, 32'h0, 0);
    #1;
    chk_req("drain_entry", 1'b1, 32'h104);
    assert_reset_midcycle("rst_drain");
    release_reset();
    drive(0, 0, 32'h0, 1);
    tick();
    drive(0, 0, 32'h0, 1);
    #1;
    chk_req("rst_drain.fetch", 1'b1, 32'h100);
    tick();
    chk_ifid("rst_drain.fetch", 1'b1, 32'h1000_0100, 32'h100, 32'h104);

    // counters: 10 clean fetches then one redirect bubble
    drive(0, 0, 32'h0, 1);
    #2 reset_i = 1'b0;
    #1;
    chk("cnt.reset_fetch",  fetch_cnt_o,  32'h0);
    chk("cnt.reset_bubble", bubble_cnt_o, 32'h0);
    release_reset();
    drive(0, 0, 32'h0, 1);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 32'h0, 1);
      tick();
    end
    chk_ifid("cnt.last_fetch", 1'b1, 32'h1000_0124, 32'h124, 32'h128);
    drive(0, 1, 32'h800, 1);
    tick();
    chk_ifid("cnt.redirect", 1'b0, 32'h13, 32'h0, 32'h0);
`ifdef IF_ID_PERF_CNT_EN
    chk("cnt.fetch",  fetch_cnt_o,  32'd10);
    chk("cnt.bubble", bubble_cnt_o, 32'd1);
`else
    chk("cnt.fetch",  fetch_cnt_o,  32'd0);
    chk("cnt.bubble", bubble_cnt_o, 32'd0);
`endif
    drive(0, 0, 32'h0, 1);
    #1;
    chk_req("cnt.after_redirect", 1'b1, 32'h800);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013: instruction word used for bubbles.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 reset_i  in  1  asynchronous, active-low reset.
REQ-005 stall_i  in  1  hazard hold request from the decode/hazard logic.
REQ-006 redirect_i  in  1  taken branch/jump from EX; kills the fetch path.
REQ-007 redirect_pc_i  in  32  redirect target; bits [1:0] ignored (forced 0).
REQ-008 imem_req_o  out  1  instruction-memory request.
REQ-009 imem_addr_o  out  32  fetch address; always equals the internal PC register.
REQ-010 imem_ready_i  in  1  imem_rdata_i valid for imem_addr_o this cycle; completes the request.
REQ-011 imem_rdata_i  in  32  fetched instruction word.
REQ-012 inst_o, pc_o, pcNext_o  out  32 each  IF/ID instruction, its PC, PC+4.
REQ-013 rs1_o, rs2_o, rd_o  out  5 each  inst[19:15], inst[24:20], inst[11:7], registered with inst_o.
REQ-014 valid_o  out  1  IF/ID holds a real instruction.
REQ-015 fetch_cnt_o, bubble_cnt_o  out  32 each  performance counters (see Configuration).

Function
REQ-016 FSM states IDLE, FETCH, HOLD, DRAIN; imem_req_o=1 only in FETCH and DRAIN.
REQ-017 While imem_req_o=1 and imem_ready_i=0, imem_addr_o SHALL stay unchanged.
REQ-018 Bubble load: inst_o=NOP_INST, rs1_o/rs2_o/rd_o=0, valid_o=0, pc_o/pcNext_o=0.
REQ-019 Hold: all IF/ID outputs keep their values.
REQ-020 IDLE -> FETCH unconditionally after one cycle; IF/ID holds its reset (bubble) contents.
REQ-021 FETCH, ready=1: redirect -> discard data, PC<=target, bubble; else stall -> capture {rdata, PC} in skid buffer, PC<=PC+4, IF/ID hold, -> HOLD; else IF/ID<={rdata, PC, PC+4}, valid_o=1, PC<=PC+4.
REQ-022 FETCH, ready=0: redirect -> buffer target, bubble, -> DRAIN; else stall -> hold; else bubble.
REQ-023 HOLD: redirect -> drop skid buffer, PC<=target, bubble, -> FETCH; else stall -> hold; else IF/ID<=skid buffer, valid_o=1, -> FETCH.
REQ-024 DRAIN: new redirect overwrites the buffered target (latest wins); on ready, discard data, PC<=buffered target, -> FETCH; IF/ID holds if stall, else bubble.
REQ-025 Priority: reset > redirect > stall > memory wait.
REQ-026 PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0); pcNext_o likewise.
REQ-027 Fetch-to-IF/ID latency: one cycle after the ready cycle; no instruction is lost or duplicated across stall/HOLD.

Reset
REQ-028 On reset_i low (asynchronous): state=IDLE, PC=RESET_PC, skid buffer and target cleared, IF/ID=bubble, counters=0.
REQ-029 Reset asserted mid-DRAIN or mid-HOLD SHALL abandon all pending work; release restarts at IDLE.

Configuration
REQ-030 Macro IF_ID_PERF_CNT_EN defined: fetch_cnt_o increments on each load with valid_o=1; bubble_cnt_o increments on each bubble load; both wrap at 2^32.
REQ-031 IF_ID_PERF_CNT_EN undefined: no counter registers; fetch_cnt_o and bubble_cnt_o tied to 0; ports remain.

Verification
REQ-032 Reset release with RESET_PC=0x100 and imem always ready -> imem_addr_o 0x100, 0x104, 0x108; pc_o follows one cycle later with valid_o=1.
REQ-033 stall_i high for 3 cycles during FETCH with ready=1 -> IF/ID frozen, state HOLD, req=0; after release, the buffered word at 0x108 appears, then 0x10C.
REQ-034 ready=0 then redirect_i to 0x200, ready returns 2 cycles later -> DRAIN, returned data discarded, next address 0x200, valid_o=0 throughout.
REQ-035 redirect_i and stall_i together in FETCH with ready=1 -> bubble loaded, PC=target, no HOLD.
REQ-036 PC=0xFFFF_FFFC fetch -> pcNext_o=0, next imem_addr_o=0.
REQ-037 With IF_ID_PERF_CNT_EN: 10 clean fetches plus 1 redirect -> fetch_cnt_o=10, bubble_cnt_o=1; without the macro both read 0.
